// File: rtl/regfile_writer.sv
// Single write-port driver for the regfile: merges pipeline writebacks with
// buffered load returns, forcing a one-cycle pipeline stall when loads starve.
module regfile_writer #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [4:0]  ld_waddr_i,
  input  logic [31:0] ld_wdata_i,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        stall_o,
  output logic [31:0] pending_mask_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [4:0]       addr_mem_q [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             we_q, we_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic        fifo_ne_s, wb_live_s, pop_s, push_s;
  logic [31:0] mask_s;

  assign fifo_ne_s  = (count_q != '0);
  assign ld_ready_o = !rst && (count_q < DEPTH_C);
  assign stall_o    = !rst && (starve_q == LIMIT_C) && fifo_ne_s;
  assign wb_live_s  = wb_we_i && (wb_waddr_i != 5'd0);
  assign pop_s      = fifo_ne_s && (stall_o || !wb_live_s);
  // Writes to x0 complete the handshake but are never queued.
  assign push_s     = ld_valid_i && ld_ready_o && (ld_waddr_i != 5'd0);

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  // Next-state for output port, occupancy and starvation counter.
  always_comb begin
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    valid_d  = valid_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (pop_s) begin
      we_d    = 1'b1;
      waddr_d = addr_mem_q[head_q];
      wdata_d = data_mem_q[head_q];
    end else if (wb_live_s) begin
      we_d    = 1'b1;
      waddr_d = wb_waddr_i;
      wdata_d = wb_wdata_i;
    end else begin
      we_d = 1'b0;
    end

    if (pop_s) begin
      valid_d[head_q] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (push_s) begin
      valid_d[tail_q] = 1'b1;
    end else begin
      valid_d = valid_d;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop_s || !fifo_ne_s) begin
      starve_d = '0;
    end else if (starve_q != LIMIT_C) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Pending-load mask built from the valid bits of queued entries.
  always_comb begin
    mask_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mask_s = mask_s | ({31'd0, valid_q[i]} << addr_mem_q[i]);
    end
    pending_mask_o = rst ? 32'd0 : mask_s;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
      valid_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      head_q   <= pop_s  ? head_q + PW'(1) : head_q;
      tail_q   <= push_s ? tail_q + PW'(1) : tail_q;
    end
  end

  // Entry storage; validity lives in valid_q so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_q[tail_q] <= ld_waddr_i;
      data_mem_q[tail_q] <= ld_wdata_i;
    end
  end

endmodule

// File: doc/regfile_writer.md
# regfile_writer

Write-port driver for `regfile`: merges the in-order pipeline writeback stream and out-of-order load returns from the memory controller onto the regfile's single `we`/`waddr`/`wdata` port. Load returns are buffered in a small FIFO behind a valid/ready handshake. A starvation counter stalls the pipeline for one cycle when queued loads would otherwise wait indefinitely. Sits between the MEM/WB stage plus memory controller on one side and `regfile` on the other. It also exports a pending-load mask to the hazard unit.

## Interface
- `DEPTH`, 4: load-return FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 3: consecutive unserved cycles with FIFO non-empty before a stall is forced (≥1).
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wb_we_i` in 1: pipeline writeback valid this cycle.
- `wb_waddr_i` in 5 (`RegAddrBus`): pipeline destination register.
- `wb_wdata_i` in 32 (`RegBus`): pipeline write data.
- `ld_valid_i` in 1: load return valid.
- `ld_ready_o` out 1: FIFO can accept a load return.
- `ld_waddr_i` in 5: load destination register.
- `ld_wdata_i` in 32: load data.
- `we` out 1: regfile write enable (registered).
- `waddr` out 5: regfile write address (registered).
- `wdata` out 32: regfile write data (registered).
- `stall_o` out 1: pipeline must hold its current writeback for this cycle (combinational).
- `pending_mask_o` out 32: bit r set while a load to xr is queued.

## Operation
- Load push: occurs when `ld_valid_i && ld_ready_o`.
  - `ld_waddr_i == 0`: handshake completes; the entry is discarded and not queued.
  - Otherwise `{waddr, wdata}` is written at the tail.
- `ld_ready_o = !rst && (count < DEPTH)`. It does not look ahead to a same-cycle pop: when full, ready stays low even if a pop occurs that cycle.
- Per-cycle selection, evaluated in priority order:
  1. `stall_o` high: pop the FIFO head to the outputs. `wb_we_i` is ignored; the pipeline re-presents it next cycle.
  2. `wb_we_i && wb_waddr_i != 0`: drive the pipeline write.
  3. FIFO non-empty: pop the head to the outputs.
  4. None of the above: `we` ← 0; `waddr`/`wdata` hold.
- `wb_we_i` with `wb_waddr_i == 0` is treated as no pipeline write. The FIFO may pop that cycle.
- Starvation counter `starve_cnt` (saturating at `STARVE_LIMIT`):
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on any pop, and whenever the FIFO is empty.
- `stall_o = (starve_cnt == STARVE_LIMIT) && count != 0`.
- Push and pop may occur in the same cycle; count is unchanged. Same-cycle push into an empty FIFO is not bypassed: the entry pops no earlier than the next cycle.
- `pending_mask_o`: OR of one-hot decodes of the valid FIFO entries' addresses.
  - Computed from registered state.
  - Multiple entries to the same register are allowed; the bit stays set until the last one pops.
- WAW ordering between pipeline writes and queued loads is not resolved here. The hazard unit uses `pending_mask_o` to prevent it.

## Timing
- Reset (synchronous, at the edge with `rst` high):
  - `we=0`, `waddr=0`, `wdata=0`.
  - FIFO empty; head/tail pointers 0; `starve_cnt=0`.
  - `pending_mask_o=0`, `stall_o=0`, `ld_ready_o=0` while `rst` is high.
- A reset mid-operation drops all queued loads and any in-flight output write.
- Pipeline path latency: 1 cycle (inputs at edge N appear on `we`/`waddr`/`wdata` after edge N).
- Load path latency: minimum 2 cycles (push at edge N, pop at edge N+1, regfile write at edge N+2). Load data is visible via the regfile bypass from edge N+1.
- `we` is high for exactly one cycle per selected write; back-to-back writes are allowed every cycle.
- Pointer wrap: modulo `DEPTH`. Count width is `$clog2(DEPTH)+1`.
- `pending_mask_o` updates the cycle after a push, and clears the cycle after the pop edge.

## Test plan
- Reset then idle → `we=0`, `ld_ready_o=1`, `pending_mask_o=0`, `stall_o=0`.
- Pipeline write x5=0xDEADBEEF, no loads → `we=1, waddr=5, wdata=0xDEADBEEF` one cycle later, for exactly one cycle; a write to x0 produces `we=0`.
- Load x7=0x12345678 pushed with pipeline idle → `pending_mask_o[7]=1` next cycle; `we=1, waddr=7` one cycle after that; mask bit clears.
- Push 4 loads (x1..x4) while the pipeline writes every cycle (`DEPTH=4`) → `ld_ready_o=0` when full. After 3 unserved cycles `stall_o=1`, x1 pops, and the pipeline write is retried next cycle. The stall then recurs every 4 cycles until the FIFO drains, in order x1..x4.
- Load to x0 with `ld_valid_i=1` → handshake accepted, count unchanged, no write ever issued.
- Assert `rst` with 3 loads queued → next cycle `pending_mask_o=0`, `we=0`. After `rst` deasserts, `ld_ready_o=1` and no stale entries are written.
